// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer and the board engine.
// Op-code values, FSM state encoding, pending-flag indices and gravity helpers.
// Pure declarations: no latency, no flow control.
package step_sequencer_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NONE   = 3'd0;
  localparam op_t OP_DOWN   = 3'd1;
  localparam op_t OP_LEFT   = 3'd2;
  localparam op_t OP_RIGHT  = 3'd3;
  localparam op_t OP_ROTATE = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam int unsigned BASE_DIV_DEFAULT = 4;

  // Bit positions inside the pending-flag vector
  localparam int PEND_DOWN  = 0;
  localparam int PEND_ROT   = 1;
  localparam int PEND_LEFT  = 2;
  localparam int PEND_RIGHT = 3;
  localparam int NUM_PEND   = 4;

  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

  // Gravity divisor max(1, base - level), done in signed 6-bit so a high
  // level can never wrap around into a huge unsigned divisor.
  function automatic logic [3:0] gravity_div(input logic [3:0] base,
                                             input logic [3:0] lvl);
    logic signed [5:0] diff;
    diff = $signed({2'b00, base}) - $signed({2'b00, lvl});
    if (diff < 6'sd1) begin
      return 4'd1;
    end
    return diff[3:0];
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Event inputs and board-command handshake between the sequencer and its peers.
// Wires only: no latency.
// Command path uses valid/ack; the sequencer holds valid until ack.
interface step_sequencer_if;
  logic       pause;
  logic       tick;
  logic [3:0] level;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rotate;
  logic       btn_down;
  logic       step_ack;
  logic       step_valid;
  logic [2:0] step_op;
  logic [7:0] drop_overrun;
  logic       busy;

  // Sequencer side
  modport master (
    input  pause, tick, level, btn_left, btn_right, btn_rotate, btn_down, step_ack,
    output step_valid, step_op, drop_overrun, busy
  );

  // Event sources and board engine side
  modport slave (
    output pause, tick, level, btn_left, btn_right, btn_rotate, btn_down, step_ack,
    input  step_valid, step_op, drop_overrun, busy
  );
endinterface

// File: rtl/step_sequencer_arbiter.sv
// Fixed-priority pick of one pending event: DOWN > ROTATE > LEFT > RIGHT.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the clear is applied.
module step_arbiter
  import step_sequencer_pkg::*;
(
  input  logic [NUM_PEND-1:0] pend_i,
  output op_t                 op_o,
  output logic [NUM_PEND-1:0] clr_o
);

  // Highest-priority set flag wins; one-hot clear marks the chosen flag
  always_comb begin
    op_o  = OP_NONE;
    clr_o = '0;
    if (pend_i[PEND_DOWN]) begin
      op_o             = OP_DOWN;
      clr_o[PEND_DOWN] = 1'b1;
    end else if (pend_i[PEND_ROT]) begin
      op_o            = OP_ROTATE;
      clr_o[PEND_ROT] = 1'b1;
    end else if (pend_i[PEND_LEFT]) begin
      op_o             = OP_LEFT;
      clr_o[PEND_LEFT] = 1'b1;
    end else if (pend_i[PEND_RIGHT]) begin
      op_o              = OP_RIGHT;
      clr_o[PEND_RIGHT] = 1'b1;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Latches gravity/button events as pending and issues one board command at a time.
// Event at edge k -> step_valid after edge k+1; one idle cycle between commands.
// step_valid/step_op held until step_ack; events keep accumulating as pending flags.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned BASE_DIV = BASE_DIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  step_sequencer_if.master bus
);

  localparam logic [3:0] BASE_DIV_L = 4'(BASE_DIV);

  state_t              state_q, state_d;
  logic [3:0]          tick_cnt_q, tick_cnt_d;
  logic [NUM_PEND-1:0] pend_q, pend_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                valid_q, valid_d;
  op_t                 op_q, op_d;

  logic [3:0]          div;
  logic [3:0]          div_m1;
  logic                ev_en;
  logic                grav_fire;
  logic                offer_go;
  logic [NUM_PEND-1:0] set_vec;
  logic [NUM_PEND-1:0] clr_vec;
  logic [NUM_PEND-1:0] arb_clr;
  op_t                 arb_op;

  assign div    = gravity_div(BASE_DIV_L, bus.level);
  assign div_m1 = div - 4'd1;
  assign ev_en  = ~bus.pause;

  // >= rather than == so a level increase mid-count fires on the next tick
  assign grav_fire = ev_en & bus.tick & (tick_cnt_q >= div_m1);

  assign set_vec[PEND_DOWN]  = ev_en & (grav_fire | bus.btn_down);
  assign set_vec[PEND_ROT]   = ev_en & bus.btn_rotate;
  assign set_vec[PEND_LEFT]  = ev_en & bus.btn_left;
  assign set_vec[PEND_RIGHT] = ev_en & bus.btn_right;

  step_arbiter u_arb (
    .pend_i (pend_q),
    .op_o   (arb_op),
    .clr_o  (arb_clr)
  );

  assign offer_go = (state_q == ST_IDLE) & ev_en & (|pend_q);
  assign clr_vec  = offer_go ? arb_clr : '0;

  // Gravity counter advances only on unpaused ticks
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (ev_en && bus.tick) begin
      tick_cnt_d = grav_fire ? 4'd0 : tick_cnt_q + 4'd1;
    end
  end

  // Clear first, then set, so an event landing on its own issue edge survives
  always_comb begin
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // Gravity lost to an already-pending DOWN is counted, saturating
  always_comb begin
    overrun_d = overrun_q;
    if (grav_fire && pend_q[PEND_DOWN] && (overrun_q != OVERRUN_MAX)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  // Event capture registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pend_q     <= '0;
      overrun_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: pause only blocks new offers, never an in-flight one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (offer_go)     state_d = ST_ISSUE;
      ST_ISSUE: if (bus.step_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: register the chosen op on offer, drop it on the ack edge
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (offer_go) begin
          valid_d = 1'b1;
          op_d    = arb_op;
        end
      end
      ST_ISSUE: begin
        if (bus.step_ack) begin
          valid_d = 1'b0;
          op_d    = OP_NONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        op_d    = OP_NONE;
      end
    endcase
  end

  // Command output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_NONE;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
    end
  end

  assign bus.step_valid   = valid_q;
  assign bus.step_op      = op_q;
  assign bus.drop_overrun = overrun_q;
  assign bus.busy         = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;
  import step_sequencer_pkg::*;

  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step_sequencer_if bus();

  step_sequencer #(.BASE_DIV(BD)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules, per clock edge) ----------
  // flag order in priority: DOWN, ROTATE, LEFT, RIGHT
  int  prio_op[4] = '{1, 4, 2, 3};
  bit  m_pend[4];
  int  m_tcnt;
  int  m_ovr;
  bit  m_busy;
  int  exp_q[$];

  always @(posedge clk) begin : model
    int  dv;
    bit  gfire;
    bit  ev[4];
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_tcnt = 0;
      m_ovr  = 0;
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      dv = BD - int'(bus.level);
      if (dv < 1) dv = 1;
      gfire = 1'b0;
      foreach (ev[i]) ev[i] = 1'b0;
      if (!bus.pause) begin
        if (bus.tick) begin
          if (m_tcnt >= dv - 1) begin
            m_tcnt = 0;
            gfire  = 1'b1;
          end else begin
            m_tcnt = m_tcnt + 1;
          end
        end
        ev[0] = gfire | bus.btn_down;
        ev[1] = bus.btn_rotate;
        ev[2] = bus.btn_left;
        ev[3] = bus.btn_right;
      end
      if (gfire && m_pend[0] && m_ovr < 255) m_ovr = m_ovr + 1;
      if (m_busy) begin
        if (bus.step_ack) m_busy = 1'b0;
      end else if (!bus.pause) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i]) begin
            exp_q.push_back(prio_op[i]);
            m_pend[i] = 1'b0;
            m_busy    = 1'b1;
            break;
          end
        end
      end
      for (int i = 0; i < 4; i++) if (ev[i]) m_pend[i] = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  int       n_xfer = 0;
  int       op_log[$];
  bit       hold_prev = 1'b0;
  logic [2:0] prev_op;

  always @(negedge clk) begin : monitor
    int e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("busy", bus.busy, m_busy);
      check("valid", bus.step_valid, m_busy);
      if (hold_prev) begin
        check("op_stable", bus.step_op, prev_op);
      end
      if (bus.step_valid && bus.step_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cmd: got op %0d, expected no command", bus.step_op);
        end else begin
          e = exp_q.pop_front();
          check("op", bus.step_op, e);
        end
        check("overrun_at_xfer", bus.drop_overrun, m_ovr);
        n_xfer++;
        op_log.push_back(int'(bus.step_op));
      end
      hold_prev = bus.step_valid && !bus.step_ack;
      prev_op   = bus.step_op;
    end
  end

  // ---------------- ack driver ---------------------------------------------
  int ack_mode  = 0;   // 0 high, 1 after ack_delay valid cycles, 2 low, 3 random
  int ack_delay = 3;
  int vcnt      = 0;

  always begin
    @(posedge clk);
    #1;
    if (bus.step_valid) vcnt++; else vcnt = 0;
    case (ack_mode)
      0:       bus.step_ack = 1'b1;
      1:       bus.step_ack = (vcnt >= ack_delay);
      2:       bus.step_ack = 1'b0;
      default: bus.step_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.tick       = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_rotate = 1'b0;
    bus.btn_down   = 1'b0;
  endtask

  task automatic count_op(input int op, output int n);
    n = 0;
    foreach (op_log[i]) if (op_log[i] == op) n++;
  endtask

  task automatic gravity_run(input int lvl, input int nticks, input int exp_downs);
    int n;
    bus.level = 4'(lvl);
    op_log.delete();
    for (int i = 0; i < nticks; i++) begin
      bus.tick = 1'b1;
      cyc();
      repeat (9) cyc();
    end
    count_op(1, n);
    check($sformatf("downs_level%0d", lvl), n, exp_downs);
  endtask

  initial begin
    int n;
    int x0;
    rst            = 1'b1;
    bus.pause      = 1'b0;
    bus.tick       = 1'b0;
    bus.level      = 4'd0;
    bus.btn_left   = 1'b1;
    bus.btn_right  = 1'b0;
    bus.btn_rotate = 1'b0;
    bus.btn_down   = 1'b0;
    bus.step_ack   = 1'b0;

    // reset with button pulses applied
    cyc();
    bus.btn_left = 1'b1;
    cyc();
    @(negedge clk);
    check("rst_valid", bus.step_valid, 0);
    check("rst_op", bus.step_op, 0);
    check("rst_overrun", bus.drop_overrun, 0);
    check("rst_busy", bus.busy, 0);
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    check("no_cmd_after_reset", n_xfer, 0);

    // gravity division, ack tied high
    ack_mode = 0;
    gravity_run(0, 16, 4);
    gravity_run(2, 16, 8);
    gravity_run(7, 8, 8);

    // priority: LEFT, ROTATE and gravity together
    ack_mode  = 1;
    ack_delay = 3;
    op_log.delete();
    bus.level      = 4'd7;
    bus.btn_left   = 1'b1;
    bus.btn_rotate = 1'b1;
    bus.tick       = 1'b1;
    cyc();
    repeat (25) cyc();
    check("prio_count", op_log.size(), 3);
    if (op_log.size() == 3) begin
      check("prio_0", op_log[0], 1);
      check("prio_1", op_log[1], 4);
      check("prio_2", op_log[2], 2);
    end

    // overrun with ack held low
    rst = 1'b1;
    cyc();
    cyc();
    rst      = 1'b0;
    ack_mode = 2;
    bus.level = 4'd7;
    for (int i = 0; i < 5; i++) begin
      bus.tick = 1'b1;
      cyc();
      repeat (9) cyc();
    end
    @(negedge clk);
    check("overrun_3", bus.drop_overrun, 3);
    check("overrun_offer_op", bus.step_op, 1);
    for (int i = 0; i < 300; i++) begin
      bus.tick = 1'b1;
      cyc();
      cyc();
    end
    @(negedge clk);
    check("overrun_sat", bus.drop_overrun, 255);
    op_log.delete();
    ack_mode = 0;
    repeat (10) cyc();
    check("overrun_drain", op_log.size(), 2);

    // pause: in-flight command survives, new events ignored
    ack_mode  = 2;
    bus.level = 4'd0;
    op_log.delete();
    bus.btn_left = 1'b1;
    cyc();
    repeat (3) cyc();
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.tick       = 1'b1;
      bus.btn_left   = 1'($urandom_range(0, 1));
      bus.btn_right  = 1'($urandom_range(0, 1));
      bus.btn_rotate = 1'($urandom_range(0, 1));
      bus.btn_down   = 1'($urandom_range(0, 1));
      cyc();
      repeat (3) cyc();
    end
    ack_mode = 0;
    repeat (5) cyc();
    check("pause_inflight_done", op_log.size(), 1);
    bus.pause = 1'b0;
    repeat (10) cyc();
    check("pause_nothing_pending", op_log.size(), 1);

    // set/clear race on the RIGHT flag
    op_log.delete();
    bus.btn_right = 1'b1;
    cyc();
    bus.btn_right = 1'b1;
    cyc();
    repeat (10) cyc();
    count_op(3, n);
    check("race_two_rights", n, 2);

    // randomized traffic
    ack_mode = 3;
    x0 = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      bus.pause      = ($urandom_range(0, 9) == 0);
      bus.tick       = ($urandom_range(0, 3) == 0);
      bus.btn_left   = ($urandom_range(0, 7) == 0);
      bus.btn_right  = ($urandom_range(0, 7) == 0);
      bus.btn_rotate = ($urandom_range(0, 7) == 0);
      bus.btn_down   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) bus.level = 4'($urandom_range(0, 15));
      cyc();
    end
    bus.pause = 1'b0;
    ack_mode  = 0;
    repeat (60) cyc();
    check("random_some_traffic", (n_xfer - x0) > 100, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Consumer of the gravity tick pulse and the single-cycle player-input pulses. Latches each event as pending, applies gravity division by game level, and issues one board-update command at a time to the board engine over a valid/ack handshake. Sits between the clock/tick generator plus debounced buttons and the board/collision logic. Runs on the 100 MHz system clock.

## Interface
- BASE_DIV, default 4: number of `tick` pulses per gravity drop at level 0; legal range 1..15.
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pause  input  1  level; freezes event capture and command issue.
- tick  input  1  one-cycle gravity base pulse from the clock block.
- level  input  4  current game level; lowers the gravity divisor.
- btn_left, btn_right, btn_rotate, btn_down  input  1 each  one-cycle debounced press pulses.
- step_ack  input  1  board engine accepts the current command.
- step_valid  output  1  command offered.
- step_op  output  3  command code: 0 NONE, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROTATE.
- drop_overrun  output  8  saturating count of gravity events lost because DOWN was already pending.
- busy  output  1  high while in ISSUE state.

## Operation
- Reset: step_valid=0, step_op=0, drop_overrun=0, busy=0, all pending flags 0, tick_count=0, state IDLE. Reset wins over every other input in the same cycle.
- Gravity divisor: div = max(1, BASE_DIV - level), computed in 5-bit signed or clamped arithmetic, with no unsigned wrap.
- Gravity counter, 4 bits: on `tick` with pause=0, if tick_count >= div-1, then tick_count<=0 and a gravity event fires; otherwise tick_count+1. The >= compare makes the next tick fire immediately when level rises mid-count.
- Pending flags: pend_down (gravity or btn_down), pend_left, pend_right, pend_rot. An event sets its flag at the clock edge it is sampled on. If pend_down is already set, a gravity event increments drop_overrun, saturating at 255. btn_down never counts as an overrun.
- While pause=1, `tick` and all buttons are ignored: no flag set, no counter change. Existing pending flags are held.
- FSM:
  - IDLE: if pause=0 and any flag is set, select by priority DOWN > ROTATE > LEFT > RIGHT. Register step_op and step_valid=1, clear the selected flag at the same edge, go to ISSUE.
  - ISSUE: hold step_valid and step_op stable until step_ack=1. On the ack edge, step_valid<=0, step_op<=0, go to IDLE. pause does not withdraw an offered command.
- Same-cycle clear and set of one flag: set wins, so the new event is kept.
- step_ack while step_valid=0 is ignored.

## Timing
- An event pulse sampled at edge k sets its flag at edge k. Earliest step_valid is after edge k+1.
- Handshake transfer occurs on the edge where step_valid and step_ack are both 1. step_valid drops after that edge.
- At least one idle cycle (valid=0) between commands. Back-to-back throughput is one command per 2 cycles with ack tied high.
- With a constant tick period T and level L, gravity DOWN events fire every max(1, BASE_DIV-L)·T cycles.

## Structure
- Shared package: op-code constants (OP_NONE..OP_ROTATE), FSM state encoding, and the BASE_DIV default, shared with the board engine.
- One natural sub-module, step_arbiter: combinational fixed-priority select from the pending flags to step_op and a one-hot clear vector. All other logic is in the top.

## Test plan
- Reset with flags set: assert rst for 2 cycles with btn_left pulses applied -> all outputs 0, no command after release.
- Gravity division: BASE_DIV=4, level=0, tick every 10 cycles, ack tied high -> DOWN issued once per 4 ticks. Set level=2 -> once per 2 ticks. Set level=7 -> every tick.
- Priority: pulse btn_left, btn_rotate and gravity in the same cycle, with ack after 3 cycles each -> ops issued DOWN, ROTATE, LEFT in order, each valid held stable until ack.
- Overrun: hold ack low for 5 gravity events -> first DOWN offered, one re-pending, drop_overrun=3. Force 300 overruns -> saturates at 255.
- Pause: pause=1 for 20 ticks with button pulses -> no flags, tick_count unchanged. An in-flight command stays valid and completes on ack.
- Set/clear race: btn_right pulse on the same edge that RIGHT is issued -> a second RIGHT is issued after the first ack.
